de2_greenled_pwm_driver: RTL and testbench
==========================================

Name: de2_greenled_pwm_driver

Overview:
- Downstream consumer of the green-LED PIO output port: takes the 9-bit LED pattern and drives the physical DE2 green LEDs.
- Adds global PWM brightness control and per-LED blinking.
- Configured by the Nios II through a small Avalon-MM slave with the same zero-wait-state register style as the PIO.
- Output feeds the board LED pins directly.

Parameters:
- NUM_LEDS, 9: width of the pattern input and LED output.
- PWM_BITS, 8: PWM counter and duty width.
- PRESCALE, 50: clk cycles per PWM tick; legal range ≥2.
- BLINK_FRAMES, 64: PWM frames per blink half-period; legal range ≥2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pattern_in  in  NUM_LEDS  LED pattern from the PIO out_port.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero-extended.
- led_out  out  NUM_LEDS  registered LED drive.

Behaviour:
- Clock and reset: single clock domain, clk; reset_n is asynchronous, active-low, and clears every register immediately.
- Write qualification: a write occurs when chipselect && ~write_n; there is no wait state.
- Register map:
  - addr 0 DUTY [PWM_BITS-1:0]: R/W, reset all-ones.
  - addr 1 BLINK_MASK [NUM_LEDS-1:0]: R/W, reset 0.
  - addr 2 CTRL: bit0 ENABLE is R/W, reset 1. bit1 BLINK_PHASE is read-only. Other bits read 0 and are ignored on write.
  - addr 3 FRAME_CNT: read-only blink counter, zero-extended.
- Read timing: readdata = selected register, zero-extended, valid in the same cycle as address.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick = 1 for one cycle when the count equals PRESCALE-1, then the count wraps to 0.
- PWM counter:
  - Increments on tick and wraps from all-ones to 0.
  - The wrap cycle asserts a one-cycle frame strobe.
- Duty shadowing:
  - Writes to DUTY update the programmer-visible register immediately.
  - duty_active loads from DUTY only on the frame strobe, so a mid-frame write never produces a glitch frame.
  - Reset value of duty_active is all-ones.
- pwm_on = (duty_active == all-ones) | (pwm_cnt < duty_active).
  - Duty 0 means always off.
  - Duty all-ones means always on, not 255/256.
- Blink counter:
  - Counts frame strobes 0..BLINK_FRAMES-1.
  - On wrap it toggles BLINK_PHASE; BLINK_PHASE resets to 0.
- Output, registered with 1-cycle latency: led_out[i] <= ENABLE & pattern_in[i] & pwm_on & ~(BLINK_MASK[i] & BLINK_PHASE).
- ENABLE = 0:
  - Prescaler, PWM counter, blink counter and BLINK_PHASE are held at 0.
  - led_out goes to 0 on the next edge.
  - Re-enabling restarts a fresh frame at pwm_cnt = 0; duty_active keeps its last value.
- Simultaneous events:
  - A DUTY write in the same cycle as the frame strobe: duty_active loads the old DUTY value; the new value applies at the next frame.
  - A BLINK_MASK write takes effect in the led_out update on the following edge.
- Reset mid-operation: all counters, duty_active, registers and led_out return to reset values asynchronously; no partial state survives.
- Writes to read-only addresses have no effect.

Optional Feature:
- Macro: DE2_GREENLED_GAMMA_EN.
- Defined: pwm compare uses duty_eff = (duty_active * duty_active) >> PWM_BITS, a square-law gamma. duty_eff is computed from duty_active in a registered stage updated at the frame strobe, so there is no added output latency. The always-on rule still keys on duty_active == all-ones.
- Undefined: duty_eff = duty_active, a linear mapping; no multiplier is instantiated.

Decomposition:
- Shared package holds:
  - register address constants ADDR_DUTY=0, ADDR_BLINK_MASK=1, ADDR_CTRL=2, ADDR_FRAME_CNT=3;
  - CTRL bit indices;
  - reset-value constants (DUTY all-ones, ENABLE 1).
- One sub-module, de2_pwm_timebase: prescaler plus PWM counter. Inputs are clk, reset_n and enable; outputs are pwm_cnt and frame_strobe. It is parameterised by PRESCALE and PWM_BITS.
- The top level keeps the Avalon registers, duty shadowing, blink logic and output register.

Test Plan:
- Reset: reset, pattern_in=9'h1FF → led_out=9'h1FF steady; readdata at addr0=0xFF, addr2=0x1.
- 25% duty: PRESCALE=2, write DUTY=0x40 mid-frame → old duty holds until the frame strobe; thereafter led_out high for exactly 64 of 256 ticks per frame.
- Duty boundaries: write DUTY=0 → led_out=0 for the whole frame; write DUTY=0xFF → led_out never drops.
- Blink: BLINK_MASK=9'h001, BLINK_FRAMES=2, pattern_in=9'h003 → led_out[0] toggles every 2 frames, led_out[1] steady; CTRL bit1 mirrors the phase.
- Disable mid-frame: write CTRL=0 → led_out=0 the next cycle and FRAME_CNT reads 0. Re-enable → first tick starts from pwm_cnt=0.
- Async reset mid-frame: assert reset_n low between clocks → led_out, counters and registers clear immediately; with DE2_GREENLED_GAMMA_EN defined, DUTY=0x80 yields 64/256 on-time.

Source files
------------

// File: rtl/de2_greenled_pwm_driver_pkg.sv
// Shared constants for the DE2 green-LED PWM driver: Avalon register map, CTRL bit
// positions and register reset values.
package de2_greenled_pwm_driver_pkg;

  localparam logic [1:0] ADDR_DUTY       = 2'd0;
  localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
  localparam logic [1:0] ADDR_CTRL       = 2'd2;
  localparam logic [1:0] ADDR_FRAME_CNT  = 2'd3;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_PHASE_BIT  = 1;

  // Wide enough for any legal PWM_BITS; the user slices the low bits.
  localparam logic [31:0] DUTY_RST   = 32'hFFFF_FFFF;
  localparam logic        ENABLE_RST = 1'b1;

endpackage

// File: rtl/de2_pwm_timebase.sv
// Prescaler plus free-running PWM counter; frame_strobe marks the cycle in which the
// PWM counter wraps from all-ones to zero. Everything is held at zero while disabled.
module de2_pwm_timebase #(
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_strobe
);

  localparam int unsigned     PRE_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_cnt;
  logic                w_tick;

  assign w_tick       = enable && (r_pre == PRE_MAX);
  assign frame_strobe = w_tick && (r_cnt == '1);
  assign pwm_cnt      = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (!enable) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/de2_greenled_pwm_driver.sv
// DE2 green-LED driver: PWM brightness and per-LED blinking applied to the PIO pattern.
// Define DE2_GREENLED_GAMMA_EN for a square-law duty curve; default is linear.
module de2_greenled_pwm_driver
  import de2_greenled_pwm_driver_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 9,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PRESCALE     = 50,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int unsigned        BLINK_W    = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_duty_active;
  logic [NUM_LEDS-1:0] r_blink_mask;
  logic                r_enable;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;
  logic [NUM_LEDS-1:0] r_led;

  logic                w_wr;
  logic [PWM_BITS-1:0] w_pwm_cnt;
  logic                w_frame_strobe;
  logic [PWM_BITS-1:0] w_duty_eff;
  logic                w_pwm_on;
  logic                w_unused_wdata;

  assign w_wr           = chipselect && !write_n;
  assign w_unused_wdata = ^writedata;

  de2_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (r_enable),
    .pwm_cnt      (w_pwm_cnt),
    .frame_strobe (w_frame_strobe)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty       <= DUTY_RST[PWM_BITS-1:0];
      r_blink_mask <= '0;
      r_enable     <= ENABLE_RST;
    end else if (w_wr) begin
      unique case (address)
        ADDR_DUTY:       r_duty       <= writedata[PWM_BITS-1:0];
        ADDR_BLINK_MASK: r_blink_mask <= writedata[NUM_LEDS-1:0];
        ADDR_CTRL:       r_enable     <= writedata[CTRL_ENABLE_BIT];
        default:         ;
      endcase
    end
  end

  // Shadow register: r_duty is sampled before any same-cycle write lands, so a write
  // coinciding with the strobe only takes effect one frame later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_active <= DUTY_RST[PWM_BITS-1:0];
    end else if (w_frame_strobe) begin
      r_duty_active <= r_duty;
    end
  end

`ifdef DE2_GREENLED_GAMMA_EN
  localparam longint unsigned DUTY_MAX = (longint'(1) << PWM_BITS) - 1;
  localparam longint unsigned EFF_RST  = (DUTY_MAX * DUTY_MAX) >> PWM_BITS;

  logic [2*PWM_BITS-1:0] w_duty_sq;
  logic [PWM_BITS-1:0]   r_duty_eff;

  assign w_duty_sq = {{PWM_BITS{1'b0}}, r_duty} * {{PWM_BITS{1'b0}}, r_duty};

  // Squared from the value being shadowed, so the curve lands with duty_active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_eff <= PWM_BITS'(EFF_RST);
    end else if (w_frame_strobe) begin
      r_duty_eff <= w_duty_sq[2*PWM_BITS-1:PWM_BITS];
    end
  end

  assign w_duty_eff = r_duty_eff;
`else
  assign w_duty_eff = r_duty_active;
`endif

  // All-ones is fully on rather than (2^N-1)/2^N.
  assign w_pwm_on = (r_duty_active == '1) || (w_pwm_cnt < w_duty_eff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!r_enable) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_strobe) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= !r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= '0;
    end else begin
      r_led <= {NUM_LEDS{r_enable && w_pwm_on}} & pattern_in &
               ~(r_blink_mask & {NUM_LEDS{r_blink_phase}});
    end
  end

  assign led_out = r_led;

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DUTY:       readdata[PWM_BITS-1:0] = r_duty;
      ADDR_BLINK_MASK: readdata[NUM_LEDS-1:0] = r_blink_mask;
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE_BIT] = r_enable;
        readdata[CTRL_PHASE_BIT]  = r_blink_phase;
      end
      ADDR_FRAME_CNT:  readdata[BLINK_W-1:0]  = r_blink_cnt;
      default:         ;
    endcase
  end

endmodule

// File: tb/tb_de2_greenled_pwm_driver.sv
// Directed bench for de2_greenled_pwm_driver with PRESCALE=2 and BLINK_FRAMES=2, so a PWM
// frame is 512 clocks and the blink phase flips every 1024 clocks.
module tb_de2_greenled_pwm_driver;

  // Expected led-high clocks per 512-clock frame for the duties used below.
`ifdef DE2_GREENLED_GAMMA_EN
  localparam int ON_DUTY_40 = 32;   // (0x40^2)>>8 = 16 ticks
  localparam int ON_DUTY_80 = 128;  // (0x80^2)>>8 = 64 ticks
  localparam int RUN_DUTY_10 = 2;   // (0x10^2)>>8 = 1 tick
`else
  localparam int ON_DUTY_40 = 128;
  localparam int ON_DUTY_80 = 256;
  localparam int RUN_DUTY_10 = 32;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  pattern_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [8:0]  led_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de2_greenled_pwm_driver #(
    .NUM_LEDS     (9),
    .PWM_BITS     (8),
    .PRESCALE     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern_in (pattern_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Leaves the bench 1 ns after the edge that re-enabled the block (pwm_cnt = 0).
  task automatic restart();
    wr(2'd2, 32'h0);
    wr(2'd2, 32'h1);
  endtask

  task automatic window(input int n, output int hi, output int lo);
    hi = 0;
    lo = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (led_out === pattern_in) hi++;
      else if (led_out === 9'h000) lo++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int hi, lo;
    reset_n    = 1'b0;
    pattern_in = 9'h1FF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #1;
    checks++;
    if (led_out !== 9'h000) begin
      errors++; $display("FAIL reset_led_low got %h want 000", led_out);
    end
    #22 reset_n = 1'b1;
    cyc(3);
    checks++;
    if (led_out !== 9'h1FF) begin
      errors++; $display("FAIL reset_led_on got %h want 1ff", led_out);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL reset_duty got %h want ff", d); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", d); end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h want 1", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_frame got %h want 0", d); end
    window(600, hi, lo);
    checks++;
    if (hi != 600) begin errors++; $display("FAIL reset_steady got %0d want 600", hi); end
  endtask

  task automatic test_duty_25();
    logic [31:0] d;
    int hi, lo;
    restart();
    cyc(49);
    wr(2'd0, 32'h40);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h40) begin errors++; $display("FAIL duty_readback got %h want 40", d); end
    window(462, hi, lo);
    checks++;
    if (hi != 462) begin errors++; $display("FAIL duty_old_holds got %0d want 462", hi); end
    cyc(87);
    window(512, hi, lo);
    checks++;
    if (hi != ON_DUTY_40 || lo != 512 - ON_DUTY_40) begin
      errors++;
      $display("FAIL duty_25 got hi=%0d lo=%0d want hi=%0d lo=%0d", hi, lo, ON_DUTY_40,
               512 - ON_DUTY_40);
    end
  endtask

  task automatic test_duty_bounds();
    int hi, lo;
    wr(2'd0, 32'h00);
    cyc(1100);
    window(512, hi, lo);
    checks++;
    if (hi != 0 || lo != 512) begin
      errors++; $display("FAIL duty_zero got hi=%0d lo=%0d want 0/512", hi, lo);
    end
    wr(2'd0, 32'hFF);
    cyc(1100);
    window(1024, hi, lo);
    checks++;
    if (hi != 1024) begin errors++; $display("FAIL duty_full got %0d want 1024", hi); end
  endtask

  task automatic test_blink();
    logic [31:0] d;
    pattern_in = 9'h003;
    wr(2'd1, 32'h001);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL blink_mask_rd got %h want 1", d); end
    restart();
    cyc(1023);
    checks++;
    if (led_out !== 9'h003) begin errors++; $display("FAIL blink_pre got %h want 003", led_out); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL blink_frame1 got %h want 1", d); end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL blink_phase0 got %h want 1", d); end
    cyc(1);
    rd(2'd2, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL blink_phase1 got %h want 3", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL blink_frame_wrap got %h want 0", d); end
    cyc(1);
    checks++;
    if (led_out !== 9'h002) begin errors++; $display("FAIL blink_off got %h want 002", led_out); end
    cyc(1023);
    rd(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL blink_phase_back got %h want 1", d); end
    cyc(1);
    checks++;
    if (led_out !== 9'h003) begin errors++; $display("FAIL blink_on got %h want 003", led_out); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    int hi, lo;
    pattern_in = 9'h1FF;
    wr(2'd1, 32'h000);
    restart();
    cyc(100);
    wr(2'd2, 32'h0);
    cyc(1);
    checks++;
    if (led_out !== 9'h000) begin errors++; $display("FAIL disable_led got %h want 000", led_out); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL disable_frame got %h want 0", d); end
    wr(2'd3, 32'h1);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ro_write got %h want 0", d); end
    // Load a short duty, then stop mid-frame and check the restarted on-run length.
    wr(2'd0, 32'h10);
    wr(2'd2, 32'h1);
    cyc(1100);
    wr(2'd2, 32'h0);
    cyc(5);
    wr(2'd2, 32'h1);
    window(RUN_DUTY_10 + 1, hi, lo);
    checks++;
    if (hi != RUN_DUTY_10 || led_out !== 9'h000) begin
      errors++;
      $display("FAIL reenable_run got hi=%0d last=%h want hi=%0d last=000", hi, led_out,
               RUN_DUTY_10);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(2'd0, 32'hFF);
    cyc(1100);
    wr(2'd0, 32'h40);
    wr(2'd1, 32'h1AA);
    restart();
    cyc(37);
    checks++;
    if (led_out !== 9'h1FF) begin errors++; $display("FAIL prereset_led got %h want 1ff", led_out); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 9'h000) begin errors++; $display("FAIL async_led got %h want 000", led_out); end
    rd(2'd0, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL async_duty got %h want ff", d); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_mask got %h want 0", d); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_frame got %h want 0", d); end
    #2 reset_n = 1'b1;
    cyc(200);
    checks++;
    if (led_out !== 9'h1FF) begin errors++; $display("FAIL postreset_led got %h want 1ff", led_out); end
  endtask

  task automatic test_duty_80();
    int hi, lo;
    wr(2'd0, 32'h80);
    cyc(1100);
    window(512, hi, lo);
    checks++;
    if (hi != ON_DUTY_80 || lo != 512 - ON_DUTY_80) begin
      errors++;
      $display("FAIL duty_80 got hi=%0d lo=%0d want hi=%0d", hi, lo, ON_DUTY_80);
    end
  endtask

  initial begin
    test_reset();
    test_duty_25();
    test_duty_bounds();
    test_blink();
    test_disable();
    test_async_reset();
    test_duty_80();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
